axil_error_endpoint: RTL and testbench

AXIL_ERROR_ENDPOINT -- requirements
Module: axil_error_endpoint

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_if.sv | 32 +++
 rtl/sat_counter.sv | 34 +++
 rtl/axil_error_endpoint.sv | 155 +++++++++++++++
 tb/tb_axil_error_endpoint.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite error endpoint.
package axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   localparam logic [31:0] RDATA_FILL_DEFAULT = 32'hDEAD_BEEF;

   // Outstanding-transaction counters; depths are limited to 1..15.
   localparam int unsigned OCNT_W = 4;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle with master (M) and slave (S) views.
interface AxiLite #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      awValid;
   logic                      awReady;
   logic [31:0]               awAddr;
   logic                      wValid;
   logic                      wReady;
   logic [DATA_WIDTH-1:0]     wData;
   logic [DATA_WIDTH/8-1:0]   wStrb;
   logic                      bValid;
   logic                      bReady;
   logic [1:0]                bResp;
   logic                      arValid;
   logic                      arReady;
   logic [31:0]               arAddr;
   logic                      rValid;
   logic                      rReady;
   logic [DATA_WIDTH-1:0]     rData;
   logic [1:0]                rResp;

   modport S (
      input  awValid, awAddr, wValid, wData, wStrb, bReady, arValid, arAddr, rReady,
      output awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
   );

   modport M (
      output awValid, awAddr, wValid, wData, wStrb, bReady, arValid, arAddr, rReady,
      input  awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = inc ? WIDTH'(1) : '0;
      end else if (inc && (value_q != '1)) begin
         value_d = value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/axil_error_endpoint.sv
// AXI-Lite slave that answers every request with a fixed error response.
// Optional address capture is enabled by defining AXIL_ERR_CAPTURE_EN.
module axil_error_endpoint
   import axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [1:0]  RESP       = RESP_DECERR,
   parameter logic [31:0] RDATA_FILL = RDATA_FILL_DEFAULT,
   parameter int unsigned WR_DEPTH   = 2,
   parameter int unsigned RD_DEPTH   = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   AxiLite.S                    bus,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] wr_err_cnt,
   output logic [CNT_WIDTH-1:0] rd_err_cnt,
   output logic [31:0]          err_addr,
   output logic                 err_is_wr,
   output logic                 err_valid
);

   localparam logic [DATA_WIDTH-1:0] RDATA = {(DATA_WIDTH/32){RDATA_FILL}};

   logic              rel_q;
   logic [OCNT_W-1:0] aw_cnt_q, aw_cnt_d;
   logic [OCNT_W-1:0] w_cnt_q,  w_cnt_d;
   logic [OCNT_W-1:0] b_cnt_q,  b_cnt_d;
   logic [OCNT_W-1:0] r_cnt_q,  r_cnt_d;

   logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [OCNT_W-1:0] aw_eff, w_eff;
   logic pair;

   // Readies are held low until the first edge after reset release.
   always_comb begin
      aw_rdy = rel_q && (({1'b0, aw_cnt_q} + {1'b0, b_cnt_q}) < (OCNT_W+1)'(WR_DEPTH));
      w_rdy  = rel_q && (({1'b0, w_cnt_q}  + {1'b0, b_cnt_q}) < (OCNT_W+1)'(WR_DEPTH));
      ar_rdy = rel_q && (r_cnt_q < OCNT_W'(RD_DEPTH));
      b_vld  = (b_cnt_q != '0);
      r_vld  = (r_cnt_q != '0);
   end

   assign aw_hs = bus.awValid && aw_rdy;
   assign w_hs  = bus.wValid  && w_rdy;
   assign b_hs  = b_vld && bus.bReady;
   assign ar_hs = bus.arValid && ar_rdy;
   assign r_hs  = r_vld && bus.rReady;

   // Pairing sees this cycle's handshakes, so at most one of aw/w stays nonzero.
   always_comb begin
      aw_eff  = aw_cnt_q + OCNT_W'(aw_hs);
      w_eff   = w_cnt_q  + OCNT_W'(w_hs);
      pair    = (aw_eff != '0) && (w_eff != '0);
      aw_cnt_d = aw_eff - OCNT_W'(pair);
      w_cnt_d  = w_eff  - OCNT_W'(pair);
      b_cnt_d  = b_cnt_q + OCNT_W'(pair) - OCNT_W'(b_hs);
      r_cnt_d  = r_cnt_q + OCNT_W'(ar_hs) - OCNT_W'(r_hs);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rel_q    <= 1'b0;
         aw_cnt_q <= '0;
         w_cnt_q  <= '0;
         b_cnt_q  <= '0;
         r_cnt_q  <= '0;
      end else begin
         rel_q    <= 1'b1;
         aw_cnt_q <= aw_cnt_d;
         w_cnt_q  <= w_cnt_d;
         b_cnt_q  <= b_cnt_d;
         r_cnt_q  <= r_cnt_d;
      end
   end

   assign bus.awReady = aw_rdy;
   assign bus.wReady  = w_rdy;
   assign bus.arReady = ar_rdy;
   assign bus.bValid  = b_vld;
   assign bus.rValid  = r_vld;
   assign bus.bResp   = RESP;
   assign bus.rResp   = RESP;
   assign bus.rData   = RDATA;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .clr   (cnt_clr),
      .inc   (b_hs),
      .value (wr_err_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .clr   (cnt_clr),
      .inc   (r_hs),
      .value (rd_err_cnt)
   );

`ifdef AXIL_ERR_CAPTURE_EN
   logic [31:0] err_addr_q, err_addr_d;
   logic        err_is_wr_q, err_is_wr_d;
   logic        err_valid_q, err_valid_d;

   // A fresh capture in the clearing cycle keeps err_valid set.
   always_comb begin
      err_addr_d  = err_addr_q;
      err_is_wr_d = err_is_wr_q;
      err_valid_d = err_valid_q;
      if (cnt_clr) begin
         err_valid_d = 1'b0;
      end
      if (ar_hs) begin
         err_addr_d  = bus.arAddr;
         err_is_wr_d = 1'b0;
         err_valid_d = 1'b1;
      end else if (aw_hs) begin
         err_addr_d  = bus.awAddr;
         err_is_wr_d = 1'b1;
         err_valid_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_addr_q  <= '0;
         err_is_wr_q <= 1'b0;
         err_valid_q <= 1'b0;
      end else begin
         err_addr_q  <= err_addr_d;
         err_is_wr_q <= err_is_wr_d;
         err_valid_q <= err_valid_d;
      end
   end

   assign err_addr  = err_addr_q;
   assign err_is_wr = err_is_wr_q;
   assign err_valid = err_valid_q;

   logic unused_wdata;
   assign unused_wdata = ^{bus.wData, bus.wStrb};
`else
   assign err_addr  = '0;
   assign err_is_wr = 1'b0;
   assign err_valid = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{bus.wData, bus.wStrb, bus.awAddr, bus.arAddr};
`endif

endmodule

// File: tb/tb_axil_error_endpoint.sv
// Directed bench for axil_error_endpoint (64-bit data, depth 2, 4-bit counters).
module tb_axil_error_endpoint;
   localparam int unsigned DW = 64;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cnt_clr;
   logic [3:0]  wr_err_cnt;
   logic [3:0]  rd_err_cnt;
   logic [31:0] err_addr;
   logic        err_is_wr;
   logic        err_valid;

   int total = 0;
   int bad   = 0;

   AxiLite #(.DATA_WIDTH(DW)) bus_if ();

   axil_error_endpoint #(
      .DATA_WIDTH (DW),
      .RESP       (2'b11),
      .RDATA_FILL (32'hDEAD_BEEF),
      .WR_DEPTH   (2),
      .RD_DEPTH   (2),
      .CNT_WIDTH  (4)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .bus        (bus_if),
      .cnt_clr    (cnt_clr),
      .wr_err_cnt (wr_err_cnt),
      .rd_err_cnt (rd_err_cnt),
      .err_addr   (err_addr),
      .err_is_wr  (err_is_wr),
      .err_valid  (err_valid)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn = 1'b0;
      cnt_clr = 1'b0;
      bus_if.awValid = 1'b0; bus_if.awAddr = '0;
      bus_if.wValid  = 1'b0; bus_if.wData  = '0; bus_if.wStrb = '0;
      bus_if.bReady  = 1'b0;
      bus_if.arValid = 1'b0; bus_if.arAddr = '0;
      bus_if.rReady  = 1'b0;

      repeat (3) tick();
      chk("rst_awready", 64'(bus_if.awReady), 64'd0);
      chk("rst_wready",  64'(bus_if.wReady),  64'd0);
      chk("rst_arready", 64'(bus_if.arReady), 64'd0);
      chk("rst_bvalid",  64'(bus_if.bValid),  64'd0);
      chk("rst_rvalid",  64'(bus_if.rValid),  64'd0);
      chk("rst_wrcnt",   64'(wr_err_cnt),     64'd0);
      chk("rst_rdcnt",   64'(rd_err_cnt),     64'd0);
      chk("rst_errvalid",64'(err_valid),      64'd0);
      chk("rst_erraddr", 64'(err_addr),       64'd0);

      aresetn = 1'b1;
      #1;
      chk("rel_awready_pre", 64'(bus_if.awReady), 64'd0);
      tick();
      chk("rel_awready", 64'(bus_if.awReady), 64'd1);
      chk("rel_wready",  64'(bus_if.wReady),  64'd1);
      chk("rel_arready", 64'(bus_if.arReady), 64'd1);

      // AW first, W three cycles later
      bus_if.awValid = 1'b1; bus_if.awAddr = 32'h100;
      tick();
      bus_if.awValid = 1'b0;
      tick(); tick();
      chk("aw_only_bvalid", 64'(bus_if.bValid), 64'd0);
      bus_if.wValid = 1'b1;
      tick();
      bus_if.wValid = 1'b0;
      chk("b_after_w_bvalid", 64'(bus_if.bValid), 64'd1);
      chk("b_resp",           64'(bus_if.bResp),  64'd3);
      chk("b_pending_wrcnt",  64'(wr_err_cnt),    64'd0);
      bus_if.bReady = 1'b1;
      tick();
      bus_if.bReady = 1'b0;
      chk("b_done_bvalid", 64'(bus_if.bValid), 64'd0);
      chk("b_done_wrcnt",  64'(wr_err_cnt),    64'd1);

      // W before AW: two W beats fit, third is stalled
      bus_if.wValid = 1'b1;
      tick();
      chk("w1_wready", 64'(bus_if.wReady), 64'd1);
      tick();
      chk("w2_wready", 64'(bus_if.wReady), 64'd0);
      chk("w2_bvalid", 64'(bus_if.bValid), 64'd0);
      bus_if.awValid = 1'b1; bus_if.awAddr = 32'h200;
      tick();
      chk("aw1_bvalid",  64'(bus_if.bValid),  64'd1);
      chk("aw1_awready", 64'(bus_if.awReady), 64'd1);
      tick();
      bus_if.awValid = 1'b0; bus_if.wValid = 1'b0;
      chk("aw2_awready", 64'(bus_if.awReady), 64'd0);
      chk("aw2_wready",  64'(bus_if.wReady),  64'd0);
      bus_if.bReady = 1'b1;
      tick();
      chk("b1_bvalid", 64'(bus_if.bValid), 64'd1);
      chk("b1_wrcnt",  64'(wr_err_cnt),    64'd2);
      tick();
      bus_if.bReady = 1'b0;
      chk("b2_bvalid", 64'(bus_if.bValid), 64'd0);
      chk("b2_wrcnt",  64'(wr_err_cnt),    64'd3);
      chk("b2_awready",64'(bus_if.awReady),64'd1);

      // back-to-back reads, one R per cycle
      bus_if.arValid = 1'b1; bus_if.arAddr = 32'h300; bus_if.rReady = 1'b1;
      tick();
      chk("ar1_rvalid", 64'(bus_if.rValid), 64'd1);
      chk("ar1_rdata",  bus_if.rData,       64'hDEADBEEF_DEADBEEF);
      chk("ar1_rresp",  64'(bus_if.rResp),  64'd3);
      chk("ar1_arready",64'(bus_if.arReady),64'd1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("ar_stream_rdcnt", 64'(rd_err_cnt), 64'(i - 1));
         chk("ar_stream_rvalid", 64'(bus_if.rValid), 64'd1);
      end
      bus_if.arValid = 1'b0;
      tick();
      bus_if.rReady = 1'b0;
      chk("ar_drain_rvalid", 64'(bus_if.rValid), 64'd0);
      chk("ar_drain_rdcnt",  64'(rd_err_cnt),    64'd4);

      // rReady low: read side fills and stalls
      bus_if.arValid = 1'b1;
      tick();
      chk("rfill1_arready", 64'(bus_if.arReady), 64'd1);
      tick();
      chk("rfill2_arready", 64'(bus_if.arReady), 64'd0);
      chk("rfill2_rvalid",  64'(bus_if.rValid),  64'd1);
      tick();
      chk("rhold_arready", 64'(bus_if.arReady), 64'd0);
      chk("rhold_rvalid",  64'(bus_if.rValid),  64'd1);
      chk("rhold_rdcnt",   64'(rd_err_cnt),     64'd4);
      bus_if.arValid = 1'b0; bus_if.rReady = 1'b1;
      tick();
      chk("rdrain1_rvalid", 64'(bus_if.rValid), 64'd1);
      chk("rdrain1_rdcnt",  64'(rd_err_cnt),    64'd5);
      tick();
      bus_if.rReady = 1'b0;
      chk("rdrain2_rvalid",  64'(bus_if.rValid),  64'd0);
      chk("rdrain2_arready", 64'(bus_if.arReady), 64'd1);
      chk("rdrain2_rdcnt",   64'(rd_err_cnt),     64'd6);

      // clear, then saturate the 4-bit read counter
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_rdcnt", 64'(rd_err_cnt), 64'd0);
      chk("clr_wrcnt", 64'(wr_err_cnt), 64'd0);
      bus_if.arValid = 1'b1; bus_if.rReady = 1'b1;
      repeat (15) tick();
      chk("sat_pre_rdcnt", 64'(rd_err_cnt), 64'd14);
      tick();
      chk("sat_at_rdcnt", 64'(rd_err_cnt), 64'd15);
      tick();
      bus_if.arValid = 1'b0;
      chk("sat_hold_rdcnt", 64'(rd_err_cnt), 64'd15);
      tick();
      chk("sat_end_rdcnt", 64'(rd_err_cnt), 64'd15);
      chk("sat_end_rvalid",64'(bus_if.rValid), 64'd0);
      bus_if.rReady = 1'b0;
      bus_if.arValid = 1'b1;
      tick();
      bus_if.arValid = 1'b0;
      cnt_clr = 1'b1; bus_if.rReady = 1'b1;
      tick();
      cnt_clr = 1'b0; bus_if.rReady = 1'b0;
      chk("clr_inc_rdcnt", 64'(rd_err_cnt), 64'd1);

      // simultaneous AW and AR: AR address wins when capturing
      bus_if.awValid = 1'b1; bus_if.awAddr = 32'h10;
      bus_if.arValid = 1'b1; bus_if.arAddr = 32'h20;
      tick();
      bus_if.awValid = 1'b0; bus_if.arValid = 1'b0;
`ifdef AXIL_ERR_CAPTURE_EN
      chk("cap_erraddr",  64'(err_addr),  64'h20);
      chk("cap_iswr",     64'(err_is_wr), 64'd0);
      chk("cap_errvalid", 64'(err_valid), 64'd1);
`else
      chk("nocap_erraddr",  64'(err_addr),  64'd0);
      chk("nocap_iswr",     64'(err_is_wr), 64'd0);
      chk("nocap_errvalid", 64'(err_valid), 64'd0);
`endif

      // reset mid-burst with B and R pending
      bus_if.wValid = 1'b1;
      tick();
      bus_if.wValid = 1'b0;
      chk("mid_bvalid", 64'(bus_if.bValid), 64'd1);
      chk("mid_rvalid", 64'(bus_if.rValid), 64'd1);
      aresetn = 1'b0;
      #1;
      chk("midrst_bvalid",  64'(bus_if.bValid),  64'd0);
      chk("midrst_rvalid",  64'(bus_if.rValid),  64'd0);
      chk("midrst_awready", 64'(bus_if.awReady), 64'd0);
      chk("midrst_rdcnt",   64'(rd_err_cnt),     64'd0);
      chk("midrst_errvalid",64'(err_valid),      64'd0);
      chk("midrst_erraddr", 64'(err_addr),       64'd0);
      tick(); tick();
      aresetn = 1'b1;
      bus_if.bReady = 1'b1; bus_if.rReady = 1'b1;
      tick();
      chk("post_awready", 64'(bus_if.awReady), 64'd1);
      tick(); tick();
      chk("post_bvalid", 64'(bus_if.bValid), 64'd0);
      chk("post_rvalid", 64'(bus_if.rValid), 64'd0);
      chk("post_wrcnt",  64'(wr_err_cnt),    64'd0);
      chk("post_rdcnt",  64'(rd_err_cnt),    64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
